// File: rtl/gbuf_arbiter_if.sv
// Requester command/response bundle plus the single-port SRAM pins for the global buffer arbiter.
// The arbiter connects through the slave modport; the requester/SRAM side uses master.
interface gbuf_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 128
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_wen;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      sram_wen;
    logic [ADDR_W-1:0]         sram_addr;
    logic [DATA_W-1:0]         sram_di;
    logic [DATA_W-1:0]         sram_do;

    modport slave (
        input  req_valid, req_wen, req_lock, req_addr, req_wdata, sram_do,
        output req_ready, rsp_valid, rsp_rdata, sram_wen, sram_addr, sram_di
    );

    modport master (
        output req_valid, req_wen, req_lock, req_addr, req_wdata, sram_do,
        input  req_ready, rsp_valid, rsp_rdata, sram_wen, sram_addr, sram_di
    );
endinterface

// File: rtl/gbuf_arbiter.sv
// Round-robin arbiter for the single-port global buffer SRAM with locked bursts
// and one-cycle-late read response routing back to the issuing requester.
module gbuf_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    gbuf_arbiter_if.slave              bus,
    output logic [$clog2(NUM_REQ)-1:0] dbg_rr_ptr_o,
    output logic                       dbg_lock_vld_o,
    output logic [$clog2(NUM_REQ)-1:0] dbg_lock_idx_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshake: a command from requester i is accepted on a rising edge where
    // req_valid[i] & req_ready[i]; ready is a one-hot grant that never depends on
    // a requester being ready for anything, and responses have no backpressure.

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [NUM_REQ-1:0] rsp_pend_q, rsp_pend_d;
    logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]  sram_di_q, sram_di_d;
    logic               sram_wen_d;

    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] grant;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        int r;
        r = v % NUM_REQ;
        return r[IDX_W-1:0];
    endfunction

    // A lock owner is the only candidate; if it drops valid the buffer idles.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!reset) begin
            if (lock_vld_q) begin
                grant_vld = bus.req_valid[lock_idx_q];
                grant_idx = lock_idx_q;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = wrap_idx(int'(rr_ptr_q) + k);
                    if (!grant_vld && bus.req_valid[cand]) begin
                        grant_vld = 1'b1;
                        grant_idx = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_vld_d  = lock_vld_q;
        lock_idx_d  = lock_idx_q;
        rsp_pend_d  = '0;
        sram_wen_d  = 1'b0;
        sram_addr_d = sram_addr_q;
        sram_di_d   = sram_di_q;
        if (grant_vld) begin
            rr_ptr_d    = wrap_idx(int'(grant_idx) + 1);
            lock_vld_d  = bus.req_lock[grant_idx];
            lock_idx_d  = grant_idx;
            sram_wen_d  = bus.req_wen[grant_idx];
            sram_addr_d = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
            sram_di_d   = bus.req_wdata[grant_idx*DATA_W +: DATA_W];
            if (!bus.req_wen[grant_idx]) begin
                rsp_pend_d = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            lock_vld_q  <= 1'b0;
            lock_idx_q  <= '0;
            rsp_pend_q  <= '0;
            sram_addr_q <= '0;
            sram_di_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_vld_q  <= lock_vld_d;
            lock_idx_q  <= lock_idx_d;
            rsp_pend_q  <= rsp_pend_d;
            sram_addr_q <= sram_addr_d;
            sram_di_q   <= sram_di_d;
        end
    end

    // Idle cycles keep the last address/data on the pins; with wen=0 that read is ignored.
    assign bus.req_ready = grant;
    assign bus.sram_wen  = sram_wen_d;
    assign bus.sram_addr = sram_addr_d;
    assign bus.sram_di   = sram_di_d;
    assign bus.rsp_valid = rsp_pend_q;
    assign bus.rsp_rdata = bus.sram_do;

    assign dbg_rr_ptr_o   = rr_ptr_q;
    assign dbg_lock_vld_o = lock_vld_q;
    assign dbg_lock_idx_o = lock_idx_q;
endmodule

// File: tb/tb_gbuf_arbiter.sv
// Bench for gbuf_arbiter: behavioural SRAM, per-scenario tasks checking grants inline,
// and a response scoreboard fed with expected read data at grant time.
module tb_gbuf_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 128;
    localparam int IDX_W   = 2;
    localparam int EXP_W   = NUM_REQ + DATA_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gbuf_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [IDX_W-1:0] dbg_rr_ptr;
    logic             dbg_lock_vld;
    logic [IDX_W-1:0] dbg_lock_idx;

    gbuf_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.slave),
        .dbg_rr_ptr_o   (dbg_rr_ptr),
        .dbg_lock_vld_o (dbg_lock_vld),
        .dbg_lock_idx_o (dbg_lock_idx)
    );

    // Behavioural single-port SRAM: registered read output.
    logic [DATA_W-1:0] sram_mem [0:1023];
    always @(posedge clk) begin
        if (bus.sram_wen) sram_mem[bus.sram_addr] <= bus.sram_di;
        else              bus.sram_do <= sram_mem[bus.sram_addr];
    end

    logic [DATA_W-1:0] model_mem [0:1023];
    logic [EXP_W-1:0]  exp_q[$];
    logic [EXP_W-1:0]  exp_e;
    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: every cycle the response pins must match the queue head, or be idle.
    always @(posedge clk) begin
        #2;
        n_cmp++;
        if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            if ({bus.rsp_valid, bus.rsp_rdata} !== exp_e) begin
                n_bad++;
                $display("FAIL rsp: got valid=%b data=%h want valid=%b data=%h",
                         bus.rsp_valid, bus.rsp_rdata, exp_e[EXP_W-1 -: NUM_REQ], exp_e[DATA_W-1:0]);
            end
        end else if (bus.rsp_valid !== '0) begin
            n_bad++;
            $display("FAIL rsp_idle: got valid=%b want 000", bus.rsp_valid);
        end
    end

    function automatic logic [DATA_W-1:0] burst_data(input int a);
        logic [31:0] w;
        w = 32'hB000_0000 + 32'(a);
        return {4{w}};
    endfunction

    task automatic set_req(input int i, input logic v, input logic w, input logic l,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req_valid[i] = v;
        bus.req_wen[i]   = w;
        bus.req_lock[i]  = l;
        bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
        bus.req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_wen   = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_reqs();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 1'b1, ADDR_W'(i + 1), {DATA_W{1'b1}});
        to_drive();
        to_drive();
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b want 000", bus.req_ready); end
        n_cmp++; if (bus.sram_wen !== 1'b0) begin n_bad++; $display("FAIL reset_wen: got %b want 0", bus.sram_wen); end
        n_cmp++; if (bus.rsp_valid !== 3'b000) begin n_bad++; $display("FAIL reset_rsp: got %b want 000", bus.rsp_valid); end
        n_cmp++; if (bus.sram_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.sram_addr); end
        n_cmp++; if (bus.sram_di !== '0) begin n_bad++; $display("FAIL reset_di: got %h want 0", bus.sram_di); end
        n_cmp++; if (dbg_lock_vld !== 1'b0) begin n_bad++; $display("FAIL reset_lock: got %b want 0", dbg_lock_vld); end
        n_cmp++; if (dbg_rr_ptr !== 2'd0) begin n_bad++; $display("FAIL reset_rr: got %0d want 0", dbg_rr_ptr); end
        to_drive();
        clear_reqs();
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] a5;
        a5 = {16{8'hA5}};
        set_req(1, 1'b1, 1'b1, 1'b0, 10'd5, a5);
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b010) begin n_bad++; $display("FAIL wr_ready: got %b want 010", bus.req_ready); end
        n_cmp++; if (bus.sram_wen !== 1'b1) begin n_bad++; $display("FAIL wr_wen: got %b want 1", bus.sram_wen); end
        n_cmp++; if (bus.sram_addr !== 10'd5) begin n_bad++; $display("FAIL wr_addr: got %0d want 5", bus.sram_addr); end
        n_cmp++; if (bus.sram_di !== a5) begin n_bad++; $display("FAIL wr_di: got %h want %h", bus.sram_di, a5); end
        model_mem[5] = a5;
        to_drive();
        set_req(1, 1'b1, 1'b0, 1'b0, 10'd5, '0);
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b010) begin n_bad++; $display("FAIL rd_ready: got %b want 010", bus.req_ready); end
        n_cmp++; if (bus.sram_wen !== 1'b0) begin n_bad++; $display("FAIL rd_wen: got %b want 0", bus.sram_wen); end
        exp_q.push_back({3'b010, a5});
        to_drive();
        clear_reqs();
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b000) begin n_bad++; $display("FAIL idle_ready: got %b want 000", bus.req_ready); end
        n_cmp++; if (bus.sram_wen !== 1'b0) begin n_bad++; $display("FAIL idle_wen: got %b want 0", bus.sram_wen); end
        n_cmp++; if (bus.sram_addr !== 10'd5) begin n_bad++; $display("FAIL idle_addr_hold: got %0d want 5", bus.sram_addr); end
        to_drive();
    endtask

    task automatic test_fill();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = burst_data(100 + i);
            set_req(i, 1'b1, 1'b1, 1'b0, ADDR_W'(10 + i), d);
            to_sample();
            n_cmp++;
            if (bus.req_ready !== 3'(1 << i)) begin
                n_bad++; $display("FAIL fill_ready[%0d]: got %b want %b", i, bus.req_ready, 3'(1 << i));
            end
            model_mem[10 + i] = d;
            to_drive();
            clear_reqs();
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 1'b0, ADDR_W'(10 + i), '0);
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b000) begin n_bad++; $display("FAIL rr_reset_ready: got %b want 000", bus.req_ready); end
        to_drive();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            int g;
            g = c % NUM_REQ;
            to_sample();
            n_cmp++;
            if (bus.req_ready !== 3'(1 << g)) begin
                n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", c, bus.req_ready, 3'(1 << g));
            end
            n_cmp++;
            if (bus.sram_addr !== ADDR_W'(10 + g)) begin
                n_bad++; $display("FAIL rr_addr[%0d]: got %0d want %0d", c, bus.sram_addr, 10 + g);
            end
            exp_q.push_back({3'(1 << g), model_mem[10 + g]});
            to_drive();
        end
        clear_reqs();
    endtask

    task automatic test_locked_burst();
        set_req(2, 1'b1, 1'b1, 1'b1, 10'd0, burst_data(0));
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b100) begin n_bad++; $display("FAIL burst_grant[0]: got %b want 100", bus.req_ready); end
        model_mem[0] = burst_data(0);
        to_drive();
        set_req(0, 1'b1, 1'b0, 1'b0, 10'd0, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 10'd2, '0);
        for (int k = 1; k < 4; k++) begin
            set_req(2, 1'b1, 1'b1, (k != 3), ADDR_W'(k), burst_data(k));
            to_sample();
            n_cmp++;
            if (bus.req_ready !== 3'b100) begin
                n_bad++; $display("FAIL burst_grant[%0d]: got %b want 100", k, bus.req_ready);
            end
            model_mem[k] = burst_data(k);
            to_drive();
        end
        set_req(2, 1'b0, 1'b0, 1'b0, '0, '0);
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b001) begin n_bad++; $display("FAIL burst_after: got %b want 001", bus.req_ready); end
        exp_q.push_back({3'b001, model_mem[0]});
        to_drive();
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b010) begin n_bad++; $display("FAIL burst_after2: got %b want 010", bus.req_ready); end
        exp_q.push_back({3'b010, model_mem[2]});
        to_drive();
        clear_reqs();

        // Owner stalls mid-burst: the lock must hold and nobody else may be granted.
        set_req(0, 1'b1, 1'b0, 1'b0, 10'd1, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 10'd3, '0);
        set_req(2, 1'b1, 1'b1, 1'b1, 10'd4, burst_data(4));
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b100) begin n_bad++; $display("FAIL stall_first: got %b want 100", bus.req_ready); end
        model_mem[4] = burst_data(4);
        to_drive();
        set_req(2, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int s = 0; s < 2; s++) begin
            to_sample();
            n_cmp++; if (bus.req_ready !== 3'b000) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 000", s, bus.req_ready); end
            n_cmp++; if (bus.sram_wen !== 1'b0) begin n_bad++; $display("FAIL stall_wen[%0d]: got %b want 0", s, bus.sram_wen); end
            n_cmp++; if (dbg_lock_vld !== 1'b1) begin n_bad++; $display("FAIL stall_lock[%0d]: got %b want 1", s, dbg_lock_vld); end
            to_drive();
        end
        set_req(2, 1'b1, 1'b1, 1'b0, 10'd5, burst_data(5));
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b100) begin n_bad++; $display("FAIL stall_resume: got %b want 100", bus.req_ready); end
        model_mem[5] = burst_data(5);
        to_drive();
        set_req(2, 1'b0, 1'b0, 1'b0, '0, '0);
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b001) begin n_bad++; $display("FAIL stall_release: got %b want 001", bus.req_ready); end
        exp_q.push_back({3'b001, model_mem[1]});
        to_drive();
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b010) begin n_bad++; $display("FAIL stall_next: got %b want 010", bus.req_ready); end
        exp_q.push_back({3'b010, model_mem[3]});
        to_drive();
        clear_reqs();
    endtask

    task automatic test_contention();
        reset = 1'b1;
        to_drive();
        reset = 1'b0;
        set_req(0, 1'b1, 1'b1, 1'b0, 10'd7, 128'h11);
        set_req(1, 1'b1, 1'b0, 1'b0, 10'd7, '0);
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b001) begin n_bad++; $display("FAIL cont_write: got %b want 001", bus.req_ready); end
        n_cmp++; if (bus.sram_wen !== 1'b1) begin n_bad++; $display("FAIL cont_wen: got %b want 1", bus.sram_wen); end
        model_mem[7] = 128'h11;
        to_drive();
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b010) begin n_bad++; $display("FAIL cont_read: got %b want 010", bus.req_ready); end
        exp_q.push_back({3'b010, 128'h11});
        to_drive();
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        set_req(2, 1'b1, 1'b1, 1'b1, 10'd8, burst_data(8));
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b100) begin n_bad++; $display("FAIL mid_first: got %b want 100", bus.req_ready); end
        model_mem[8] = burst_data(8);
        to_drive();
        set_req(2, 1'b1, 1'b0, 1'b1, 10'd8, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 10'd10, '0);
        reset = 1'b1;
        to_sample();
        n_cmp++; if (dbg_lock_vld !== 1'b1 || dbg_lock_idx !== 2'd2) begin
            n_bad++; $display("FAIL mid_lock_held: got vld=%b idx=%0d want vld=1 idx=2", dbg_lock_vld, dbg_lock_idx);
        end
        n_cmp++; if (bus.req_ready !== 3'b000) begin n_bad++; $display("FAIL mid_reset_ready: got %b want 000", bus.req_ready); end
        n_cmp++; if (bus.sram_wen !== 1'b0) begin n_bad++; $display("FAIL mid_reset_wen: got %b want 0", bus.sram_wen); end
        to_drive();
        reset = 1'b0;
        to_sample();
        n_cmp++; if (bus.rsp_valid !== 3'b000) begin n_bad++; $display("FAIL mid_rsp: got %b want 000", bus.rsp_valid); end
        n_cmp++; if (dbg_lock_vld !== 1'b0) begin n_bad++; $display("FAIL mid_lock_clear: got %b want 0", dbg_lock_vld); end
        n_cmp++; if (bus.req_ready !== 3'b010) begin n_bad++; $display("FAIL mid_first_grant: got %b want 010", bus.req_ready); end
        exp_q.push_back({3'b010, model_mem[10]});
        to_drive();
        clear_reqs();
        to_sample();
        n_cmp++; if (bus.req_ready !== 3'b000) begin n_bad++; $display("FAIL mid_idle: got %b want 000", bus.req_ready); end
        to_drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_fill();
        test_round_robin();
        test_locked_burst();
        test_contention();
        test_reset_mid();
        to_drive();
        to_drive();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL drain: got %0d pending responses want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gbuf_arbiter.md
# gbuf_arbiter

Round-robin arbiter and sequencer for the single-port global buffer SRAM (128-bit words). It shares the buffer between NUM_REQ requesters, for example the DMA loader, the PE-array operand fetch and the output writeback. Each requester issues single-word read or write commands over a valid/ready handshake. The block grants one command per cycle, drives the SRAM port and routes the one-cycle-late read data back to the issuing requester. It also supports locked bursts, so one requester can hold the buffer for consecutive accesses.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 10, SRAM word-address width
- DATA_W, 128, SRAM word width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_wen  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  keep the grant after this command (burst continues)
- req_addr  in  NUM_REQ*ADDR_W  word address; requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  write data; requester i at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant; command accepted when valid & ready
- rsp_valid  out  NUM_REQ  one-hot; read data for requester i is on rsp_rdata
- rsp_rdata  out  DATA_W  read data, shared by all requesters
- sram_wen  out  1  to SRAM wen
- sram_addr  out  ADDR_W  to SRAM addr
- sram_di  out  DATA_W  to SRAM DI
- sram_do  in  DATA_W  from SRAM DO (registered, valid the cycle after a read)

## Operation
- State:
  - rr_ptr: index of the highest-priority requester.
  - lock_own: valid bit plus index of the requester holding a burst lock.
  - rsp_pend: one-hot register recording the read issued last cycle.
- Grant, combinational within the cycle:
  - If lock_own is valid: only the owner can be granted. It is granted if req_valid[owner]=1; otherwise no grant this cycle.
  - Otherwise: grant the first requester with req_valid=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready is the one-hot grant, and is 0 for every requester with req_valid=0.
- SRAM drive:
  - With a grant g: sram_wen=req_wen[g], sram_addr=req_addr[g], sram_di=req_wdata[g].
  - With no grant: sram_wen=0, and sram_addr/sram_di hold their last granted values. The resulting idle read is harmless and produces no response.
- On an accepted command from g:
  - rr_ptr <= (g+1) mod NUM_REQ.
  - If req_lock[g]=1: lock_own <= {1,g}. Otherwise lock_own valid <= 0.
- Lock release happens only when the owner's accepted command has req_lock=0. An owner deasserting req_valid stalls the buffer; it does not release the lock.
- Read response:
  - rsp_pend <= one-hot(g) when the accepted command is a read, else 0.
  - rsp_valid = rsp_pend.
  - rsp_rdata = sram_do, passed straight through.
- Write then read to the same address in consecutive cycles returns the new data. The SRAM writes at edge t and reads at edge t+1.
- No backpressure on responses: requesters must sink rsp_valid unconditionally.
- Reset: rr_ptr=0, lock_own invalid, rsp_pend=0. While reset=1, req_ready=0 and sram_wen=0. A read issued in the cycle reset asserts produces no response.

## Timing
- Command accept at edge t. A write is committed in SRAM at edge t.
- Read latency 1: rsp_valid high for exactly the cycle after acceptance.
- Throughput: one command per cycle, aggregate over all requesters.
- Fairness: with all requesters continuously valid and no locks, each is granted once every NUM_REQ cycles.
- Worst-case wait for an unlocked requester: NUM_REQ-1 cycles plus any active burst length.
- Reset values of outputs: req_ready=0, rsp_valid=0, sram_wen=0, sram_addr=0, sram_di=0. rsp_rdata follows sram_do.

## Test plan
- Single write then read, NUM_REQ=3:
  - Stimulus: requester 1 writes 128'hA5A5...A5 to addr 5, then reads addr 5.
  - Required: ready on both cycles; rsp_valid=3'b010 one cycle after the read, with rsp_rdata=128'hA5A5...A5.
- Round robin:
  - Stimulus: all 3 requesters hold reads valid from reset.
  - Required: grant sequence 0,1,2,0,1,2; rsp_valid follows the same sequence delayed by 1 cycle.
- Locked burst:
  - Stimulus: requester 2 issues 4 writes (addr 0..3) with lock=1,1,1,0 while requesters 0 and 1 are valid.
  - Required: requester 2 is granted for 4 consecutive cycles, then requester 0.
  - Stimulus variant: requester 2 drops valid mid-burst for 2 cycles.
  - Required: no grants during those 2 cycles.
- Read/write contention:
  - Stimulus: requester 0 writes 0x11 to addr 7 in the same cycle that requester 1 reads addr 7; rr_ptr=0.
  - Required: the write is granted first; the read is granted the next cycle and returns 0x11.
- Reset mid-operation:
  - Stimulus: assert reset during a locked burst with a read outstanding.
  - Required: rsp_valid=0 in the next cycle, lock cleared, and after release the first grant goes to the lowest-index valid requester.
